// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed byte stream into little-endian 32-bit instruction
// memory writes from word 0 upward. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module imem_loader #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic                  cpu_hold
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM   = 3'd4,
`endif
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_t S_AFTER_DATA = S_CSUM;
`else
   localparam state_t S_AFTER_DATA = S_DONE;
`endif

   localparam logic [16:0] CAPACITY = 17'(2**ADDR_WIDTH);

   state_t      state, state_nxt;
   logic [7:0]  len_lo;
   logic [16:0] len;
   logic [16:0] len_rx;
   logic [16:0] word_idx;
   logic [1:0]  byte_cnt;
   logic [23:0] word_buf;
   logic        accept;
   logic        start_ok;
   logic        last_word_written;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   assign accept            = in_valid && in_ready;
   assign start_ok          = start && !busy;
   assign len_rx            = {1'b0, in_data, len_lo};
   // word_idx reaches len in the cycle the final word is on the memory port.
   assign last_word_written = (word_idx == len);

   always_comb begin
      in_ready = 1'b0;
      unique case (state)
         S_LEN_LO, S_LEN_HI: in_ready = 1'b1;
         S_DATA:             in_ready = !last_word_written;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM:             in_ready = 1'b1;
`endif
         default:            in_ready = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b1;
      done      = 1'b0;
      error     = 1'b0;
      cpu_hold  = 1'b1;
      unique case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            busy     = 1'b0;
            done     = (state == S_DONE);
            error    = (state == S_ERROR);
            cpu_hold = (state != S_DONE);
            if (start) state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (accept) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (accept) begin
               if (len_rx == 17'd0)         state_nxt = S_AFTER_DATA;
               else if (len_rx > CAPACITY)  state_nxt = S_ERROR;
               else                         state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (last_word_written) state_nxt = S_AFTER_DATA;
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_lo    <= '0;
         len       <= '0;
         word_idx  <= '0;
         byte_cnt  <= '0;
         word_buf  <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
      end else begin
         mem_we <= 1'b0;
         if (start_ok) begin
            word_idx <= '0;
            byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
         end
         if (accept) begin
            unique case (state)
               S_LEN_LO: len_lo <= in_data;
               S_LEN_HI: len    <= len_rx;
               S_DATA: begin
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum     <= csum ^ in_data;
`endif
                  // Bytes enter at the top and shift down, so the first byte ends up as the LSB.
                  if (byte_cnt == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= word_idx[ADDR_WIDTH-1:0];
                     mem_wdata <= {in_data, word_buf};
                     word_idx  <= word_idx + 17'd1;
                  end else begin
                     word_buf  <= {in_data, word_buf[23:8]};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
